// File: rtl/boss_fsm.sv
// Boss-enemy controller: horizontal chase within clamped bounds, bullet hits with invulnerability window, death.
// Optional enrage mode (double step, halved walk divider at half health) is enabled by defining BOSS_ENRAGE_EN.
module boss_fsm #(
  parameter int X_CENTER    = 500,
  parameter int Y_CENTER    = 389,
  parameter int SIZE        = 50,
  parameter int X_MIN       = 1,
  parameter int X_MAX       = 639,
  parameter int SPEED       = 1,
  parameter int MAX_HEALTH  = 350,
  parameter int DAMAGE      = 10,
  parameter int HIT_MARGIN  = 30,
  parameter int HURT_FRAMES = 30,
  parameter int WALK_DIV    = 15
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       active,
  input  logic [9:0] PlayerX,
  input  logic [9:0] PlayerY,
  input  logic [9:0] PlayerS,
  input  logic [9:0] bulletX,
  input  logic [9:0] bulletY,
  input  logic       bullet_valid,
  output logic [9:0] BossX,
  output logic [9:0] BossY,
  output logic [9:0] BossS,
  output logic [1:0] walk_frame,
  output logic       is_walking,
  output logic       direction,
  output logic [9:0] health,
  output logic [1:0] state,
  output logic       hit,
  output logic       dead,
  output logic       enraged
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHASE = 2'd1,
    ST_HURT  = 2'd2,
    ST_DEAD  = 2'd3
  } state_t;

  localparam logic [10:0] X_LO      = 11'(X_MIN + SIZE);
  localparam logic [10:0] X_HI      = 11'(X_MAX - SIZE);
  localparam logic [10:0] SIZE_W    = 11'(SIZE);
  localparam logic [10:0] Y_LO      = (Y_CENTER >= SIZE + HIT_MARGIN) ?
                                      11'(Y_CENTER - SIZE - HIT_MARGIN) : 11'd0;
  localparam logic [10:0] Y_HI      = 11'(Y_CENTER + SIZE + HIT_MARGIN);
  localparam logic [9:0]  DAMAGE_W  = 10'(DAMAGE);
  localparam logic [15:0] HURT_LOAD = 16'(HURT_FRAMES - 1);
  localparam logic [15:0] WALK_FULL = 16'(WALK_DIV);
  localparam logic [15:0] WALK_HALF = 16'(WALK_DIV / 2);

  state_t      state_q, state_d;
  logic [9:0]  boss_x_q, boss_x_d;
  logic [9:0]  health_q, health_d;
  logic        direction_q, direction_d;
  logic [1:0]  walk_frame_q, walk_frame_d;
  logic [15:0] walk_cnt_q, walk_cnt_d;
  logic        is_walking_q, is_walking_d;
  logic        hit_q, hit_d;
  logic        dead_q, dead_d;
  logic        enraged_q, enraged_d;
  logic [15:0] hurt_cnt_q, hurt_cnt_d;

  logic        enrage_now;
  logic [10:0] bx_w, step, target, clamped;
  logic [15:0] walk_div;
  logic        move_r, move_l, bullet_hit;
  logic [9:0]  health_hit;
  logic        unused_player_y;

  assign unused_player_y = ^PlayerY;

`ifdef BOSS_ENRAGE_EN
  localparam logic [9:0] HALF_HEALTH = 10'(MAX_HEALTH / 2);
  assign enrage_now = (health_q <= HALF_HEALTH);
`else
  assign enrage_now = 1'b0;
`endif

  // Movement target, bounds clamp and hitbox test, all on the current boss position.
  always_comb begin
    bx_w     = {1'b0, boss_x_q};
    step     = enrage_now ? 11'(2 * SPEED) : 11'(SPEED);
    walk_div = enrage_now ? WALK_HALF : WALK_FULL;
    move_r   = (bx_w + {1'b0, PlayerS}) < {1'b0, PlayerX};
    move_l   = bx_w > ({1'b0, PlayerX} + {1'b0, PlayerS});
    if (move_r) begin
      target = bx_w + step;
    end else if (move_l) begin
      target = (bx_w > step) ? (bx_w - step) : 11'd0;
    end else begin
      target = bx_w;
    end
    if (target < X_LO) begin
      clamped = X_LO;
    end else if (target > X_HI) begin
      clamped = X_HI;
    end else begin
      clamped = target;
    end
    bullet_hit = bullet_valid
              && ({1'b0, bulletX} >= ((bx_w > SIZE_W) ? (bx_w - SIZE_W) : 11'd0))
              && ({1'b0, bulletX} <= (bx_w + SIZE_W))
              && ({1'b0, bulletY} >= Y_LO)
              && ({1'b0, bulletY} <= Y_HI);
    health_hit = (health_q > DAMAGE_W) ? (health_q - DAMAGE_W) : 10'd0;
  end

  always_comb begin
    state_d      = state_q;
    boss_x_d     = boss_x_q;
    health_d     = health_q;
    direction_d  = direction_q;
    enraged_d    = enraged_q;
    hurt_cnt_d   = hurt_cnt_q;
    dead_d       = dead_q;
    is_walking_d = 1'b0;
    hit_d        = 1'b0;
    walk_cnt_d   = 16'd0;
    walk_frame_d = 2'd0;

    if (!active) begin
      state_d     = ST_IDLE;
      boss_x_d    = 10'(X_CENTER);
      health_d    = 10'(MAX_HEALTH);
      direction_d = 1'b1;
      enraged_d   = 1'b0;
      hurt_cnt_d  = 16'd0;
      dead_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_CHASE;
        ST_CHASE: begin
          boss_x_d     = clamped[9:0];
          is_walking_d = (move_r || move_l) && (clamped != bx_w);
          if (move_r) begin
            direction_d = 1'b1;
          end else if (move_l) begin
            direction_d = 1'b0;
          end
          enraged_d = enrage_now;
          if (bullet_hit) begin
            health_d = health_hit;
            hit_d    = 1'b1;
            if (health_hit == 10'd0) begin
              state_d = ST_DEAD;
              dead_d  = 1'b1;
            end else begin
              state_d    = ST_HURT;
              hurt_cnt_d = HURT_LOAD;
            end
          end
        end
        ST_HURT: begin
          if (hurt_cnt_q == 16'd0) begin
            state_d = ST_CHASE;
          end else begin
            hurt_cnt_d = hurt_cnt_q - 16'd1;
          end
        end
        default: dead_d = 1'b1;
      endcase
    end

    // >= rather than == so a shrinking divider cannot strand the counter past its wrap point.
    if (is_walking_d) begin
      if (walk_cnt_q >= walk_div - 16'd1) begin
        walk_cnt_d   = 16'd0;
        walk_frame_d = (walk_frame_q == 2'd2) ? 2'd0 : (walk_frame_q + 2'd1);
      end else begin
        walk_cnt_d   = walk_cnt_q + 16'd1;
        walk_frame_d = walk_frame_q;
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      boss_x_q     <= 10'(X_CENTER);
      health_q     <= 10'(MAX_HEALTH);
      direction_q  <= 1'b1;
      walk_frame_q <= 2'd0;
      walk_cnt_q   <= 16'd0;
      is_walking_q <= 1'b0;
      hit_q        <= 1'b0;
      dead_q       <= 1'b0;
      enraged_q    <= 1'b0;
      hurt_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      boss_x_q     <= boss_x_d;
      health_q     <= health_d;
      direction_q  <= direction_d;
      walk_frame_q <= walk_frame_d;
      walk_cnt_q   <= walk_cnt_d;
      is_walking_q <= is_walking_d;
      hit_q        <= hit_d;
      dead_q       <= dead_d;
      enraged_q    <= enraged_d;
      hurt_cnt_q   <= hurt_cnt_d;
    end
  end

  assign BossX      = boss_x_q;
  assign BossY      = 10'(Y_CENTER);
  assign BossS      = 10'(SIZE);
  assign walk_frame = walk_frame_q;
  assign is_walking = is_walking_q;
  assign direction  = direction_q;
  assign health     = health_q;
  assign state      = state_q;
  assign hit        = hit_q;
  assign dead       = dead_q;
  assign enraged    = enraged_q;

endmodule

// File: tb/tb_boss_fsm.sv
// Testbench for boss_fsm: directed scenarios plus randomized play checked against a frame-level behavioural model.
module tb_boss_fsm;

  localparam int X_CENTER    = 500;
  localparam int Y_CENTER    = 389;
  localparam int SIZE        = 50;
  localparam int X_MIN       = 1;
  localparam int X_MAX       = 639;
  localparam int SPEED       = 1;
  localparam int MAX_HEALTH  = 350;
  localparam int DAMAGE      = 10;
  localparam int HIT_MARGIN  = 30;
  localparam int HURT_FRAMES = 30;
  localparam int WALK_DIV    = 15;

`ifdef BOSS_ENRAGE_EN
  localparam bit ENR = 1'b1;
`else
  localparam bit ENR = 1'b0;
`endif

  logic       frame_clk = 1'b0;
  logic       Reset, active, bullet_valid;
  logic [9:0] PlayerX, PlayerY, PlayerS, bulletX, bulletY;
  logic [9:0] BossX, BossY, BossS, health;
  logic [1:0] walk_frame, state;
  logic       is_walking, direction, hit, dead, enraged;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  int m_x, m_health, m_state, m_dir, m_walking, m_hit, m_enraged;
  int m_run, m_div, m_hurt_start;

  always #5 frame_clk = ~frame_clk;

  boss_fsm dut (
    .frame_clk(frame_clk), .Reset(Reset), .active(active),
    .PlayerX(PlayerX), .PlayerY(PlayerY), .PlayerS(PlayerS),
    .bulletX(bulletX), .bulletY(bulletY), .bullet_valid(bullet_valid),
    .BossX(BossX), .BossY(BossY), .BossS(BossS),
    .walk_frame(walk_frame), .is_walking(is_walking), .direction(direction),
    .health(health), .state(state), .hit(hit), .dead(dead), .enraged(enraged)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed != expected) begin
      bad++;
      $display("[TB] FAIL %s @cycle %0d: got %0d, expected %0d", tag, cycle, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_x = X_CENTER; m_health = MAX_HEALTH; m_state = 0; m_dir = 1;
    m_walking = 0; m_hit = 0; m_enraged = 0; m_run = 0; m_div = WALK_DIV;
  endtask

  // One frame of the game rules, evaluated on the inputs present at the clock edge.
  task automatic modelStep();
    int px, ps, bx, by, nx, step, lo_x;
    bit enr, overlap;
    cycle++;
    if (Reset || !active) begin
      modelReset();
      return;
    end
    px = int'(PlayerX); ps = int'(PlayerS); bx = int'(bulletX); by = int'(bulletY);
    m_hit = 0;
    m_walking = 0;
    case (m_state)
      0: m_state = 1;
      1: begin
        enr  = ENR && (m_health <= MAX_HEALTH / 2);
        step = enr ? 2 * SPEED : SPEED;
        nx   = m_x;
        if (m_x + ps < px) begin
          nx = m_x + step; m_dir = 1;
        end else if (m_x > px + ps) begin
          nx = m_x - step; m_dir = 0;
        end
        if (nx < X_MIN + SIZE) nx = X_MIN + SIZE;
        if (nx > X_MAX - SIZE) nx = X_MAX - SIZE;
        m_walking = (nx != m_x);
        m_div     = enr ? WALK_DIV / 2 : WALK_DIV;
        m_enraged = enr;
        lo_x      = (m_x - SIZE < 0) ? 0 : m_x - SIZE;
        overlap   = bullet_valid && bx >= lo_x && bx <= m_x + SIZE
                    && by >= ((Y_CENTER - SIZE - HIT_MARGIN < 0) ? 0 : Y_CENTER - SIZE - HIT_MARGIN)
                    && by <= Y_CENTER + SIZE + HIT_MARGIN;
        m_x = nx;
        if (overlap) begin
          m_health = (m_health > DAMAGE) ? m_health - DAMAGE : 0;
          m_hit = 1;
          if (m_health == 0) begin
            m_state = 3;
          end else begin
            m_state = 2;
            m_hurt_start = cycle;
          end
        end
      end
      2: if (cycle - m_hurt_start >= HURT_FRAMES) m_state = 1;
      default: ;
    endcase
    m_run = m_walking ? m_run + 1 : 0;
  endtask

  task automatic checkModel();
    checkOutput("BossX", int'(BossX), m_x);
    checkOutput("BossY", int'(BossY), Y_CENTER);
    checkOutput("BossS", int'(BossS), SIZE);
    checkOutput("health", int'(health), m_health);
    checkOutput("state", int'(state), m_state);
    checkOutput("direction", int'(direction), m_dir);
    checkOutput("is_walking", int'(is_walking), m_walking);
    checkOutput("walk_frame", int'(walk_frame), m_walking ? (m_run / m_div) % 3 : 0);
    checkOutput("hit", int'(hit), m_hit);
    checkOutput("dead", int'(dead), (m_state == 3) ? 1 : 0);
    checkOutput("enraged", int'(enraged), m_enraged);
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge frame_clk);
      modelStep();
      #1;
      checkModel();
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_x"}, int'(BossX), 500);
    checkOutput({tag, "_y"}, int'(BossY), 389);
    checkOutput({tag, "_health"}, int'(health), 350);
    checkOutput({tag, "_state"}, int'(state), 0);
    checkOutput({tag, "_dir"}, int'(direction), 1);
    checkOutput({tag, "_dead"}, int'(dead), 0);
    checkOutput({tag, "_hit"}, int'(hit), 0);
    checkOutput({tag, "_enraged"}, int'(enraged), 0);
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must clear without a clock.
  task automatic asyncResetPulse();
    #2 Reset = 1'b1;
    #1;
    modelReset();
    checkModel();
    checkResetValues("async_rst");
    #1 Reset = 1'b0;
  endtask

  initial begin
    int hold, guard, xb, r;
    Reset = 1'b1; active = 1'b0; bullet_valid = 1'b0;
    PlayerX = '0; PlayerY = 10'd389; PlayerS = '0; bulletX = '0; bulletY = '0;
    modelReset();
    #12;
    checkResetValues("rst");
    @(negedge frame_clk);
    Reset = 1'b0;

    // Chase left toward a player at 100 with half-size 20.
    active = 1'b1; PlayerX = 10'd100; PlayerS = 10'd20;
    applyStimulus(400);
    checkOutput("chase_end_x", int'(BossX), 120);
    checkOutput("chase_end_walk", int'(is_walking), 0);
    checkOutput("chase_end_dir", int'(direction), 0);

    // Player at the far right edge: boss saturates at X_MAX-SIZE.
    PlayerX = 10'd639; PlayerS = 10'd0;
    applyStimulus(500);
    checkOutput("clamp_x", int'(BossX), 589);
    checkOutput("clamp_walk", int'(is_walking), 0);

    // Bullet parked on the boss: one hit, 30-frame HURT window, then the next hit.
    bullet_valid = 1'b1; bulletX = 10'(m_x); bulletY = 10'd389;
    applyStimulus(1);
    checkOutput("hit1_health", int'(health), 340);
    checkOutput("hit1_pulse", int'(hit), 1);
    checkOutput("hit1_state", int'(state), 2);
    applyStimulus(1);
    checkOutput("hit1_drop", int'(hit), 0);
    applyStimulus(29);
    checkOutput("hurt_over_state", int'(state), 1);
    checkOutput("hurt_over_health", int'(health), 340);
    applyStimulus(1);
    checkOutput("hit2_health", int'(health), 330);

    // Keep firing until death, then leave gameplay.
    applyStimulus(1100);
    checkOutput("death_health", int'(health), 0);
    checkOutput("death_state", int'(state), 3);
    checkOutput("death_dead", int'(dead), 1);
    checkOutput("death_x", int'(BossX), 589);
    active = 1'b0; bullet_valid = 1'b0;
    applyStimulus(1);
    checkResetValues("inactive");

    // Mid-HURT asynchronous reset.
    active = 1'b1; bullet_valid = 1'b1; bulletX = 10'(X_CENTER); PlayerX = 10'(X_CENTER); PlayerS = 10'd0;
    applyStimulus(5);
    checkOutput("pre_rst_state", int'(state), 2);
    asyncResetPulse();

    // Walk left under fire until health reaches 170, then watch the first post-HURT chase step.
    PlayerX = 10'd0; PlayerS = 10'd0;
    guard = 0;
    while (m_health > 170 && guard < 1200) begin
      bulletX = 10'(m_x);
      applyStimulus(1);
      guard++;
    end
    checkOutput("enrage_setup_health", int'(health), 170);
    bullet_valid = 1'b0;
    applyStimulus(30);
    xb = int'(BossX);
    applyStimulus(1);
    checkOutput("enrage_step", xb - int'(BossX), ENR ? 2 : 1);
    checkOutput("enrage_flag", int'(enraged), ENR ? 1 : 0);

    // Randomized play.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        PlayerX = 10'($urandom_range(0, 700));
        PlayerS = 10'($urandom_range(0, 60));
        hold = int'($urandom_range(1, 80));
      end
      hold--;
      active = ($urandom_range(0, 199) != 0);
      bullet_valid = ($urandom_range(0, 3) == 0);
      r = m_x + int'($urandom_range(0, 160)) - 80;
      bulletX = 10'((r < 0) ? 0 : r);
      bulletY = 10'($urandom_range(280, 500));
      applyStimulus(1);
      if ($urandom_range(0, 499) == 0) asyncResetPulse();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
